// File: rtl/segre_pkg.sv
// Shared widths, opcodes and stage types for the segre M-extension pipeline.
package segre_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int REG_SIZE       = 5;
  localparam int M_EXT_STAGES   = 5;
  localparam int DIV_ITERATIONS = 32;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_ext_opcode_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [REG_SIZE-1:0]  waddr;
    m_ext_opcode_e        opcode;
    logic [WORD_SIZE-1:0] data;
  } m_stage_t;

  function automatic logic is_div_op(input m_ext_opcode_e op);
    return (op == M_DIV) || (op == M_DIVU) || (op == M_REM) || (op == M_REMU);
  endfunction

endpackage

// File: rtl/segre_m_ext_chk.sv
// Protocol checker for the M-extension pipeline issue handshake.
module segre_m_ext_chk (
  input logic clk_i,
  input logic rst_i,
  input logic valid_m1_i,
  input logic busy_i
);

  // Decode must hold while a divide occupies M1; such an issue would be dropped.
  property p_no_issue_when_busy;
    @(posedge clk_i) disable iff (rst_i) !(valid_m1_i && busy_i);
  endproperty

  a_no_issue_when_busy: assert property (p_no_issue_when_busy);

endmodule

// File: rtl/segre_m_ext_div.sv
// Iterative radix-2 restoring divider with special-case shortcut and sign fix-up.
module segre_m_ext_div
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  m_ext_opcode_e        opcode_i,
  input  logic [WORD_SIZE-1:0] src_a_i,
  input  logic [WORD_SIZE-1:0] src_b_i,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] result_o
);

  div_state_e           r_state;
  logic [4:0]           r_count;
  logic [WORD_SIZE-1:0] r_rem, r_quo, r_dvsr;
  logic                 r_neg_q, r_neg_r, r_is_rem;

  logic                 w_signed, w_a_neg, w_b_neg, w_div_zero, w_ovf;
  logic [WORD_SIZE-1:0] w_abs_a, w_abs_b;
  logic [33:0]          w_diff;

  always_comb begin
    w_signed   = (opcode_i == M_DIV) || (opcode_i == M_REM);
    w_a_neg    = w_signed & src_a_i[31];
    w_b_neg    = w_signed & src_b_i[31];
    w_abs_a    = w_a_neg ? (32'd0 - src_a_i) : src_a_i;
    w_abs_b    = w_b_neg ? (32'd0 - src_b_i) : src_b_i;
    w_div_zero = (src_b_i == 32'd0);
    w_ovf      = w_signed && (src_a_i == 32'h8000_0000) && (src_b_i == 32'hFFFF_FFFF);
    // Trial subtraction of the divisor from the shifted partial remainder
    w_diff     = {1'b0, r_rem, r_quo[31]} - {2'b00, r_dvsr};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= DIV_IDLE;
      r_count <= 5'd0;
    end else begin
      case (r_state)
        DIV_CALC: begin
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= DIV_DONE;
        end
        default: begin
          // DONE falls back to IDLE unless a new divide enters M1 on the same edge
          if (start_i) begin
            r_count <= 5'd0;
            r_state <= (w_div_zero || w_ovf) ? DIV_DONE : DIV_CALC;
          end else begin
            r_state <= DIV_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i && (r_state != DIV_CALC)) begin
      r_is_rem <= (opcode_i == M_REM) || (opcode_i == M_REMU);
      if (w_div_zero) begin
        r_quo   <= 32'hFFFF_FFFF;
        r_rem   <= src_a_i;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_quo   <= 32'h8000_0000;
        r_rem   <= 32'd0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quo   <= w_abs_a;
        r_rem   <= 32'd0;
        r_dvsr  <= w_abs_b;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else if (r_state == DIV_CALC) begin
      if (!w_diff[33]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= {r_rem[30:0], r_quo[31]};
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

  assign done_o   = (r_state == DIV_DONE);
  assign result_o = r_is_rem ? (r_neg_r ? (32'd0 - r_rem) : r_rem)
                             : (r_neg_q ? (32'd0 - r_quo) : r_quo);

endmodule

// File: rtl/segre_m_ext_pipeline.sv
// Five-stage M-extension pipeline: pipelined 33x33 multiplier, optional iterative divider.
// Divide support is built only when SEGRE_M_EXT_DIV_EN is defined.
module segre_m_ext_pipeline
  import segre_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             valid_m1_i,
  input  m_ext_opcode_e                    m1_opcode_i,
  input  logic                             m1_rf_we_i,
  input  logic [REG_SIZE-1:0]              m1_rf_waddr_i,
  input  logic [WORD_SIZE-1:0]             m1_rf_src_a_i,
  input  logic [WORD_SIZE-1:0]             m1_rf_src_b_i,
  output logic                             busy_o,
  output logic                             m5_valid_o,
  output logic                             m5_rf_we_o,
  output logic [REG_SIZE-1:0]              m5_rf_waddr_o,
  output logic [WORD_SIZE-1:0]             m5_rd_data_o,
  output logic [M_EXT_STAGES-1:0]          m_pending_o,
  output logic [M_EXT_STAGES*REG_SIZE-1:0] m_pending_waddr_o,
  output logic                             m5_illegal_o
);

  m_stage_t             r_m1, r_m2, r_m3;
  logic [32:0]          r_m1_a, r_m1_b;
  logic [31:0]          r_pp_ll, r_pp_hh;
  logic [33:0]          r_pp_lh, r_pp_hl;
  logic [63:0]          r_m3_prod;
  logic                 r_m4_valid, r_m4_we, r_m5_valid, r_m5_we;
  logic [REG_SIZE-1:0]  r_m4_waddr, r_m5_waddr;
  logic [WORD_SIZE-1:0] r_m4_data, r_m5_data;

  logic                 w_busy, w_m1_adv, w_accept, w_a_signed, w_b_signed, w_m4_we;
  logic [WORD_SIZE-1:0] w_m2_data, w_m4_data;
  logic [31:0]          w_pp_ll, w_pp_hh;
  logic [33:0]          w_pp_lh, w_pp_hl;
  logic [63:0]          w_prod;

`ifdef SEGRE_M_EXT_DIV_EN
  logic                 w_m1_is_div, w_div_done;
  logic [WORD_SIZE-1:0] w_div_result;

  segre_m_ext_div u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (w_accept & is_div_op(m1_opcode_i)),
    .opcode_i (m1_opcode_i),
    .src_a_i  (m1_rf_src_a_i),
    .src_b_i  (m1_rf_src_b_i),
    .done_o   (w_div_done),
    .result_o (w_div_result)
  );

  assign w_m1_is_div  = r_m1.valid & is_div_op(r_m1.opcode);
  assign w_busy       = w_m1_is_div & ~w_div_done;
  assign w_m2_data    = w_m1_is_div ? w_div_result : r_m1.data;
  assign w_m4_we      = r_m3.we;
  assign m5_illegal_o = 1'b0;
`else
  logic r_m4_ill, r_m5_ill;

  assign w_busy       = 1'b0;
  assign w_m2_data    = r_m1.data;
  assign w_m4_we      = r_m3.we & ~is_div_op(r_m3.opcode);
  assign m5_illegal_o = r_m5_ill;

  // Divide opcodes retire as illegal when no divider is built
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m4_ill <= 1'b0;
      r_m5_ill <= 1'b0;
    end else begin
      r_m4_ill <= r_m3.valid & is_div_op(r_m3.opcode);
      r_m5_ill <= r_m4_valid & r_m4_ill;
    end
  end
`endif

  assign w_m1_adv   = ~w_busy;
  assign w_accept   = valid_m1_i & ~w_busy;
  assign w_a_signed = (m1_opcode_i == M_MULH) || (m1_opcode_i == M_MULHSU);
  assign w_b_signed = (m1_opcode_i == M_MULH);

  // 16-bit unsigned low halves, 17-bit signed high halves
  always_comb begin
    w_pp_ll = {16'd0, r_m1_a[15:0]} * {16'd0, r_m1_b[15:0]};
    w_pp_lh = {18'd0, r_m1_a[15:0]} * {{17{r_m1_b[32]}}, r_m1_b[32:16]};
    w_pp_hl = {{17{r_m1_a[32]}}, r_m1_a[32:16]} * {18'd0, r_m1_b[15:0]};
    w_pp_hh = {{15{r_m1_a[32]}}, r_m1_a[32:16]} * {{15{r_m1_b[32]}}, r_m1_b[32:16]};
    // Bits 65:64 of the full product are never selected, so only 64 are summed
    w_prod  = {32'd0, r_pp_ll}
            + {{14{r_pp_lh[33]}}, r_pp_lh, 16'd0}
            + {{14{r_pp_hl[33]}}, r_pp_hl, 16'd0}
            + {r_pp_hh, 32'd0};
  end

  always_comb begin
    case (r_m3.opcode)
      M_MUL:                     w_m4_data = r_m3_prod[31:0];
      M_MULH, M_MULHSU, M_MULHU: w_m4_data = r_m3_prod[63:32];
      default:                   w_m4_data = r_m3.data;
    endcase
  end

  // Stage control: M1 holds under an unfinished divide, M2-M5 always advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m1.valid <= 1'b0;
      r_m2.valid <= 1'b0;
      r_m3.valid <= 1'b0;
      r_m4_valid <= 1'b0;
      r_m5_valid <= 1'b0;
      r_m5_we    <= 1'b0;
    end else begin
      if (w_m1_adv) begin
        r_m1.valid  <= valid_m1_i;
        r_m1.we     <= m1_rf_we_i;
        r_m1.waddr  <= m1_rf_waddr_i;
        r_m1.opcode <= m1_opcode_i;
        r_m1.data   <= {WORD_SIZE{1'b0}};
      end
      r_m2.valid  <= r_m1.valid & w_m1_adv;
      r_m2.we     <= r_m1.we;
      r_m2.waddr  <= r_m1.waddr;
      r_m2.opcode <= r_m1.opcode;
      r_m2.data   <= w_m2_data;
      r_m3        <= r_m2;
      r_m4_valid  <= r_m3.valid;
      r_m4_we     <= w_m4_we;
      r_m4_waddr  <= r_m3.waddr;
      r_m4_data   <= w_m4_data;
      r_m5_valid  <= r_m4_valid;
      r_m5_we     <= r_m4_valid & r_m4_we;
      r_m5_waddr  <= r_m4_waddr;
      r_m5_data   <= r_m4_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_m1_adv) begin
      r_m1_a <= {w_a_signed & m1_rf_src_a_i[31], m1_rf_src_a_i};
      r_m1_b <= {w_b_signed & m1_rf_src_b_i[31], m1_rf_src_b_i};
    end
    r_pp_ll   <= w_pp_ll;
    r_pp_lh   <= w_pp_lh;
    r_pp_hl   <= w_pp_hl;
    r_pp_hh   <= w_pp_hh;
    r_m3_prod <= w_prod;
  end

  segre_m_ext_chk u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_m1_i (valid_m1_i),
    .busy_i     (w_busy)
  );

  assign busy_o            = w_busy;
  assign m5_valid_o        = r_m5_valid;
  assign m5_rf_we_o        = r_m5_we;
  assign m5_rf_waddr_o     = r_m5_waddr;
  assign m5_rd_data_o      = r_m5_data;
  assign m_pending_o       = {r_m5_valid, r_m4_valid, r_m3.valid, r_m2.valid, r_m1.valid};
  assign m_pending_waddr_o = {r_m5_waddr, r_m4_waddr, r_m3.waddr, r_m2.waddr, r_m1.waddr};

endmodule
